// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : Fetch-stage BTB + 2-bit BHT predictor trained by execute-stage
//            branch resolutions; one-cycle registered lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs_pkg;
    typedef logic [31:0] u32_t;
    typedef enum logic [3:0] {
        BRU_NONE = 4'd0,
        BRU_BEQ  = 4'd1,
        BRU_BNE  = 4'd2,
        BRU_BLT  = 4'd3,
        BRU_BLTU = 4'd4,
        BRU_BGE  = 4'd5,
        BRU_BGEU = 4'd6,
        BRU_B    = 4'd7,
        BRU_BL   = 4'd8,
        BRU_JIRL = 4'd9
    } bru_op_t;
endpackage

module branch_predictor
    import cpu_defs_pkg::*;
#(
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = 8,
    parameter int BHT_IDX_W = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req_valid,
    input  u32_t    req_pc,
    output logic    resp_valid,
    output logic    resp_taken,
    output u32_t    resp_target,
    input  logic    flush,
    input  logic    upd_valid,
    input  u32_t    upd_pc,
    input  bru_op_t upd_op,
    input  logic    upd_taken,
    input  u32_t    upd_target
);

    localparam int         c_btb_entries = 1 << BTB_IDX_W;
    localparam int         c_bht_entries = 1 << BHT_IDX_W;
    localparam logic [1:0] c_ctr_reset   = 2'b01;

    logic                 r_btb_valid  [c_btb_entries];
    logic [BTB_TAG_W-1:0] r_btb_tag    [c_btb_entries];
    logic [29:0]          r_btb_target [c_btb_entries];
    logic                 r_btb_uncond [c_btb_entries];
    logic [1:0]           r_bht        [c_bht_entries];

    logic r_req_q;
    logic r_resp_taken;
    u32_t r_resp_target;

    logic [BTB_IDX_W-1:0] w_req_btb_idx;
    logic [BTB_TAG_W-1:0] w_req_tag;
    logic [BHT_IDX_W-1:0] w_req_bht_idx;
    logic                 w_hit;
    logic                 w_pred_taken;
    u32_t                 w_pred_target;

    logic [BTB_IDX_W-1:0] w_upd_btb_idx;
    logic [BTB_TAG_W-1:0] w_upd_tag;
    logic [BHT_IDX_W-1:0] w_upd_bht_idx;
    logic                 w_upd_cond;
    logic                 w_upd_uncond;
    logic                 w_btb_we;
    logic                 w_bht_we;
    logic [1:0]           w_ctr_cur;
    logic [1:0]           w_ctr_next;
    logic                 w_unused;

    assign w_req_btb_idx = req_pc[BTB_IDX_W+1:2];
    assign w_req_tag     = req_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign w_req_bht_idx = req_pc[BHT_IDX_W+1:2];
    assign w_upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
    assign w_upd_tag     = upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign w_upd_bht_idx = upd_pc[BHT_IDX_W+1:2];
    assign w_unused      = ^{req_pc, upd_pc, upd_target[1:0]};

    // Tables are read from the current flop state, so a same-cycle update is not seen
    assign w_hit         = r_btb_valid[w_req_btb_idx] && (r_btb_tag[w_req_btb_idx] == w_req_tag);
    assign w_pred_taken  = w_hit && (r_btb_uncond[w_req_btb_idx] || r_bht[w_req_bht_idx][1]);
    assign w_pred_target = w_pred_taken ? {r_btb_target[w_req_btb_idx], 2'b00} : req_pc + 32'd4;

    always_comb begin
        w_upd_cond   = 1'b0;
        w_upd_uncond = 1'b0;
        case (upd_op)
            BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BLTU, BRU_BGE, BRU_BGEU: w_upd_cond   = 1'b1;
            BRU_B, BRU_BL, BRU_JIRL:                                w_upd_uncond = 1'b1;
            default: ;
        endcase
    end

    assign w_btb_we  = upd_valid && (w_upd_uncond || (w_upd_cond && upd_taken));
    assign w_bht_we  = upd_valid && w_upd_cond;
    assign w_ctr_cur = r_bht[w_upd_bht_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (upd_taken && (w_ctr_cur != 2'b11)) begin
            w_ctr_next = w_ctr_cur + 2'b01;
        end else if (!upd_taken && (w_ctr_cur != 2'b00)) begin
            w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_btb_entries; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
            for (int j = 0; j < c_bht_entries; j++) begin
                r_bht[j] <= c_ctr_reset;
            end
        end else begin
            if (w_btb_we) begin
                r_btb_valid[w_upd_btb_idx] <= 1'b1;
            end
            if (w_bht_we) begin
                r_bht[w_upd_bht_idx] <= w_ctr_next;
            end
        end
    end

    // Payload fields are qualified by the valid bit and need no reset
    always_ff @(posedge clk) begin
        if (w_btb_we) begin
            r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
            r_btb_target[w_upd_btb_idx] <= upd_target[31:2];
            r_btb_uncond[w_upd_btb_idx] <= w_upd_uncond;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q       <= 1'b0;
            r_resp_taken  <= 1'b0;
            r_resp_target <= 32'd0;
        end else begin
            r_req_q <= req_valid;
            if (req_valid) begin
                r_resp_taken  <= w_pred_taken;
                r_resp_target <= w_pred_target;
            end
        end
    end

    assign resp_valid  = r_req_q && !flush;
    assign resp_taken  = r_resp_taken;
    assign resp_target = r_resp_target;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Vector-table and scoreboard bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    import cpu_defs_pkg::*;

    logic    clk;
    logic    rst;
    logic    req_valid;
    u32_t    req_pc;
    logic    resp_valid;
    logic    resp_taken;
    u32_t    resp_target;
    logic    flush;
    logic    upd_valid;
    u32_t    upd_pc;
    bru_op_t upd_op;
    logic    upd_taken;
    u32_t    upd_target;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .resp_valid  (resp_valid),
        .resp_taken  (resp_taken),
        .resp_target (resp_target),
        .flush       (flush),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_op      (upd_op),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_upd;
        u32_t       pc;
        bru_op_t    op;
        logic       taken;
        u32_t       target;
        logic       chk_ctr;
        logic [1:0] exp_ctr;
        logic       exp_taken;
        u32_t       exp_target;
    } vec_t;

    typedef struct {
        logic taken;
        u32_t target;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (resp_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got taken=%0b target=%h, required no response", resp_taken, resp_target);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_taken !== e.taken || resp_target !== e.target) begin
                    n_bad++;
                    $display("FAIL resp: got taken=%0b target=%h, required taken=%0b target=%h",
                             resp_taken, resp_target, e.taken, e.target);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic add_u(input u32_t pc, input bru_op_t op, input logic tk, input u32_t tgt,
                         input logic chk_c, input logic [1:0] ctr);
        vec_t v;
        v = '{1'b1, pc, op, tk, tgt, chk_c, ctr, 1'b0, 32'd0};
        vecs.push_back(v);
    endtask

    task automatic add_l(input u32_t pc, input logic et, input u32_t etgt);
        vec_t v;
        v = '{1'b0, pc, BRU_NONE, 1'b0, 32'd0, 1'b0, 2'b00, et, etgt};
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic et, input u32_t etgt);
        exp_t e;
        e.taken  = et;
        e.target = etgt;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input u32_t pc, input logic et, input u32_t etgt);
        req_valid = 1'b1;
        req_pc    = pc;
        push_exp(et, etgt);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ctr_chk(input string name, input u32_t pc, input logic [1:0] exp);
        logic [7:0] idx;
        idx = pc[9:2];
        chk(name, {30'd0, dut.r_bht[idx]}, {30'd0, exp});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_op = BRU_NONE; upd_taken = 1'b0; upd_target = '0;

        add_l(32'h1C000100, 1'b0, 32'h1C000104);
        add_u(32'h1C000200, BRU_BEQ, 1'b1, 32'h1C000180, 1'b1, 2'b10);
        add_l(32'h1C000200, 1'b1, 32'h1C000180);
        add_u(32'h1C000200, BRU_BEQ, 1'b1, 32'h1C000180, 1'b1, 2'b11);
        add_l(32'h1C000200, 1'b1, 32'h1C000180);
        add_u(32'h1C000200, BRU_BEQ, 1'b1, 32'h1C000180, 1'b1, 2'b11);
        add_u(32'h1C000200, BRU_BEQ, 1'b0, 32'h1C000180, 1'b1, 2'b10);
        add_l(32'h1C000200, 1'b1, 32'h1C000180);
        add_u(32'h1C000200, BRU_BEQ, 1'b0, 32'h0,        1'b1, 2'b01);
        add_u(32'h1C000200, BRU_BEQ, 1'b0, 32'h0,        1'b1, 2'b00);
        add_u(32'h1C000200, BRU_BEQ, 1'b0, 32'h0,        1'b1, 2'b00);
        add_l(32'h1C000200, 1'b0, 32'h1C000204);
        add_u(32'h1C000300, BRU_BEQ, 1'b0, 32'h0,        1'b1, 2'b00);
        add_l(32'h1C000300, 1'b0, 32'h1C000304);
        add_u(32'h1C000300, BRU_BL,  1'b1, 32'h1C001000, 1'b1, 2'b00);
        add_l(32'h1C000300, 1'b1, 32'h1C001000);
        add_u(32'h1C000010, BRU_BNE, 1'b1, 32'h1C000050, 1'b1, 2'b10);
        add_l(32'h1C000010, 1'b1, 32'h1C000050);
        add_u(32'h1C000110, BRU_BNE, 1'b1, 32'h1C000060, 1'b0, 2'b00);
        add_l(32'h1C000010, 1'b0, 32'h1C000014);
        add_l(32'h1C000110, 1'b1, 32'h1C000060);
        add_u(32'h1C000504, BRU_JIRL, 1'b0, 32'h1C002000, 1'b0, 2'b00);
        add_l(32'h1C000504, 1'b1, 32'h1C002000);
        add_u(32'h1C000504, BRU_JIRL, 1'b1, 32'h1C003000, 1'b0, 2'b00);
        add_l(32'h1C000504, 1'b1, 32'h1C003000);
        add_u(32'h1C000010, BRU_NONE, 1'b1, 32'h1C009000, 1'b1, 2'b10);
        add_l(32'h1C000010, 1'b0, 32'h1C000014);
        add_l(32'hFFFFFFFC, 1'b0, 32'h00000000);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_resp_valid",  {31'd0, resp_valid}, 32'd0);
        chk("reset_resp_taken",  {31'd0, resp_taken}, 32'd0);
        chk("reset_resp_target", resp_target, 32'd0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_upd) begin
                upd_valid  = 1'b1;
                upd_pc     = vecs[i].pc;
                upd_op     = vecs[i].op;
                upd_taken  = vecs[i].taken;
                upd_target = vecs[i].target;
                tick();
                upd_valid = 1'b0;
                if (vecs[i].chk_ctr) ctr_chk("bht_counter", vecs[i].pc, vecs[i].exp_ctr);
            end else begin
                lookup(vecs[i].pc, vecs[i].exp_taken, vecs[i].exp_target);
            end
        end

        // Lookup and B update to the same slot in one cycle
        upd_valid = 1'b1; upd_pc = 32'h1C000400; upd_op = BRU_B;
        upd_taken = 1'b1; upd_target = 32'h1C000800;
        req_valid = 1'b1; req_pc = 32'h1C000400;
        push_exp(1'b0, 32'h1C000404);
        tick();
        upd_valid = 1'b0;
        push_exp(1'b1, 32'h1C000800);
        tick();
        req_valid = 1'b0;

        // Flush kills the older response; the flush-cycle request and update survive
        req_valid = 1'b1; req_pc = 32'h1C000100;
        tick();
        req_pc = 32'h1C000104; flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h1C000608; upd_op = BRU_BEQ;
        upd_taken = 1'b1; upd_target = 32'h1C000700;
        push_exp(1'b0, 32'h1C000108);
        @(negedge clk);
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_resp_valid", {31'd0, resp_valid}, 32'd1);
        tick();
        lookup(32'h1C000608, 1'b1, 32'h1C000700);

        // Reset with a request and update in flight
        rst = 1'b1;
        req_valid = 1'b1; req_pc = 32'h1C000300;
        upd_valid = 1'b1; upd_pc = 32'h1C000310; upd_op = BRU_B;
        upd_taken = 1'b1; upd_target = 32'h1C000900;
        tick();
        rst = 1'b0; req_valid = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        lookup(32'h1C000300, 1'b0, 32'h1C000304);
        lookup(32'h1C000504, 1'b0, 32'h1C000508);
        lookup(32'h1C000110, 1'b0, 32'h1C000114);
        lookup(32'h1C000310, 1'b0, 32'h1C000314);
        lookup(32'h1C000608, 1'b0, 32'h1C00060C);
        lookup(32'h1C000200, 1'b0, 32'h1C000204);
        ctr_chk("rst_bht_200", 32'h1C000200, 2'b01);
        ctr_chk("rst_bht_300", 32'h1C000300, 2'b01);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
